// File: rtl/adc_captura_flujo.sv
// ADC0804-style capture front end for the spirometer flow path.
// Runs the CS_n/WR_n/RD_n/INTR_n handshake on each iCE tick, averages 2^AVG_LOG2
// conversions and publishes one 8-bit flow sample with a one-cycle oValid strobe.
module adc_captura_flujo #(
  parameter int unsigned WR_PULSE_CYC  = 10,
  parameter int unsigned RD_ACCESS_CYC = 10,
  parameter int unsigned TIMEOUT_CYC   = 10000,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iCE,
  input  logic       iINTR_n,
  input  logic [7:0] ivDB,
  output logic       oCS_n,
  output logic       oWR_n,
  output logic       oRD_n,
  output logic [7:0] ovDatos,
  output logic       oValid,
  output logic       oError
);

  localparam int unsigned MaxWrRd = (WR_PULSE_CYC > RD_ACCESS_CYC) ? WR_PULSE_CYC
                                                                   : RD_ACCESS_CYC;
  localparam int unsigned MaxCyc  = (MaxWrRd > TIMEOUT_CYC) ? MaxWrRd : TIMEOUT_CYC;
  localparam int unsigned TmrW    = $clog2(MaxCyc + 1);
  localparam int unsigned AccW    = 8 + AVG_LOG2;
  localparam int unsigned CntW    = AVG_LOG2 + 1;

  localparam logic [TmrW-1:0] WrLast  = TmrW'(WR_PULSE_CYC - 1);
  localparam logic [TmrW-1:0] RdLast  = TmrW'(RD_ACCESS_CYC - 1);
  localparam logic [TmrW-1:0] ToLast  = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(1 << AVG_LOG2);

  typedef enum logic [2:0] {
    StIdle,
    StWrLow,
    StWaitIntr,
    StRdLow,
    StAccum,
    StPublish
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [7:0]      raw_q, raw_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic            rd_n_q, rd_n_d;

  logic [AccW-1:0] acc_sum;
  logic [CntW-1:0] cnt_inc;

  // Next-state, datapath and strobe decode; strobes are registered from state_d so the
  // ADC pins are glitch-free and line up exactly with the state they belong to.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    raw_d   = raw_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = error_q;
    sync1_d = iINTR_n;
    sync2_d = sync1_q;
    acc_sum = acc_q + AccW'(raw_q);
    cnt_inc = cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (iCE) begin
          state_d = StWrLow;
          tmr_d   = '0;
        end
      end
      StWrLow: begin
        if (tmr_q == WrLast) begin
          state_d = StWaitIntr;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StWaitIntr: begin
        // INTR is checked first so it wins a tie with the timeout.
        if (!sync2_q) begin
          state_d = StRdLow;
          tmr_d   = '0;
        end else if (tmr_q == ToLast) begin
          state_d = StIdle;
          error_d = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StRdLow: begin
        if (tmr_q == RdLast) begin
          raw_d   = ivDB;
          state_d = StAccum;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StAccum: begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
        if (cnt_inc == CntFull) begin
          // Output register loads here so ovDatos and oValid are both live in PUBLISH.
          state_d = StPublish;
          data_d  = acc_sum[AccW-1:AVG_LOG2];
          valid_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StPublish: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    wr_n_d = (state_d != StWrLow);
    rd_n_d = (state_d != StRdLow);
    cs_n_d = wr_n_d & rd_n_d;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iReset) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      raw_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      raw_q   <= raw_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
    end
  end

  assign oCS_n   = cs_n_q;
  assign oWR_n   = wr_n_q;
  assign oRD_n   = rd_n_q;
  assign ovDatos = data_q;
  assign oValid  = valid_q;
  assign oError  = error_q;

endmodule

// File: tb/tb_adc_captura_flujo.sv
// Scoreboard bench for adc_captura_flujo: an averaging instance (AVG_LOG2=2) and a
// pass-through instance (AVG_LOG2=0) share clock, reset, iCE and one ADC model.
module tb_adc_captura_flujo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       intr_n = 1'b1;
  logic [7:0] adc_db = 8'd0;

  logic       cs_m, wr_m, rd_m, val_m, err_m;
  logic [7:0] dat_m;
  logic       cs_p, wr_p, rd_p, val_p, err_p;
  logic [7:0] dat_p;

  int nvec = 0;
  int nmis = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_p[$];

  always #5 clk = ~clk;

  adc_captura_flujo #(
    .WR_PULSE_CYC (10),
    .RD_ACCESS_CYC(10),
    .TIMEOUT_CYC  (100),
    .AVG_LOG2     (2)
  ) dut_m (
    .iClk   (clk),
    .iReset (rst_n),
    .iCE    (ce),
    .iINTR_n(intr_n),
    .ivDB   (adc_db),
    .oCS_n  (cs_m),
    .oWR_n  (wr_m),
    .oRD_n  (rd_m),
    .ovDatos(dat_m),
    .oValid (val_m),
    .oError (err_m)
  );

  adc_captura_flujo #(
    .WR_PULSE_CYC (10),
    .RD_ACCESS_CYC(10),
    .TIMEOUT_CYC  (100),
    .AVG_LOG2     (0)
  ) dut_p (
    .iClk   (clk),
    .iReset (rst_n),
    .iCE    (ce),
    .iINTR_n(intr_n),
    .ivDB   (adc_db),
    .oCS_n  (cs_p),
    .oWR_n  (wr_p),
    .oRD_n  (rd_p),
    .ovDatos(dat_p),
    .oValid (val_p),
    .oError (err_p)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC model: INTR_n falls intr_delay negedges after WR_n rises; RD_n low clears it.
  int   intr_delay = 50;
  bit   intr_en = 1'b1;
  int   intr_cnt = 0;
  bit   armed = 1'b0;
  logic wr_prev = 1'b1;

  always @(negedge clk) begin
    if (wr_prev == 1'b0 && wr_m == 1'b1) begin
      intr_cnt = intr_delay;
      armed    = intr_en;
    end else if (armed) begin
      intr_cnt--;
      if (intr_cnt == 0) begin
        intr_n = 1'b0;
        armed  = 1'b0;
      end
    end
    if (rd_m == 1'b0) intr_n = 1'b1;
    wr_prev = wr_m;
  end

  // Strobe monitor: pulse widths and strobe exclusivity on both instances.
  logic [1:0] wr_v, rd_v, cs_v;
  assign wr_v = {wr_p, wr_m};
  assign rd_v = {rd_p, rd_m};
  assign cs_v = {cs_p, cs_m};
  int wr_len[2] = '{0, 0};
  int rd_len[2] = '{0, 0};
  int wr_falls = 0;
  bit cut = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!wr_v[i]) begin
        if (i == 0 && wr_len[0] == 0) wr_falls++;
        wr_len[i]++;
      end else if (wr_len[i] != 0) begin
        chk("wr_width", wr_len[i], 10);
        wr_len[i] = 0;
      end
      if (!rd_v[i]) begin
        rd_len[i]++;
      end else if (rd_len[i] != 0) begin
        if (!cut) chk("rd_width", rd_len[i], 10);
        rd_len[i] = 0;
      end
      chk("wr_rd_overlap", int'(!wr_v[i] && !rd_v[i]), 0);
      chk("cs_decode", int'(cs_v[i]), int'(wr_v[i] & rd_v[i]));
    end
  end

  // Scoreboard monitor: every oValid pops one expected sample.
  logic vprev_m = 1'b0;
  logic vprev_p = 1'b0;

  always @(negedge clk) begin
    if (val_m) begin
      if (q_m.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL valid_m: unexpected pulse with data %0d, expected no pulse", dat_m);
      end else begin
        chk("data_m", int'(dat_m), int'(q_m.pop_front()));
      end
      chk("valid_m_width", int'(vprev_m), 0);
    end
    if (val_p) begin
      if (q_p.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL valid_p: unexpected pulse with data %0d, expected no pulse", dat_p);
      end else begin
        chk("data_p", int'(dat_p), int'(q_p.pop_front()));
      end
      chk("valid_p_width", int'(vprev_p), 0);
    end
    vprev_m = val_m;
    vprev_p = val_p;
  end

  task automatic pulse_ce();
    @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  // One successful conversion; busy adds extra iCE ticks while it is in flight.
  task automatic conv(input logic [7:0] db, input int delay, input bit busy);
    adc_db     = db;
    intr_delay = delay;
    intr_en    = 1'b1;
    q_p.push_back(db);
    pulse_ce();
    if (busy) begin
      for (int i = 0; i < 10; i++) begin
        repeat (4) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
      end
    end
    repeat (160) @(negedge clk);
  endtask

  task automatic group4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [7:0] avg, input int delay);
    conv(a, delay, 1'b0);
    conv(b, delay, 1'b0);
    conv(c, delay, 1'b0);
    q_m.push_back(avg);
    conv(d, delay, 1'b0);
  endtask

  initial begin
    int n;
    int w0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_cs", int'(cs_m), 1);
    chk("rst_wr", int'(wr_m), 1);
    chk("rst_rd", int'(rd_m), 1);
    chk("rst_data", int'(dat_m), 0);
    chk("rst_valid", int'(val_m), 0);
    chk("rst_error", int'(err_m), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic timing with 0xA5, then averaging groups.
    group4(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 50);
    chk("timing_error", int'(err_m), 0);
    group4(8'd10, 8'd20, 8'd30, 8'd41, 8'd25, 50);
    group4(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 50);

    // INTR reaches the FSM on the same cycle the timer expires: read wins.
    conv(8'hA5, 97, 1'b0);
    chk("race_error_m", int'(err_m), 0);
    chk("race_error_p", int'(err_p), 0);

    // Extra iCE ticks during conversions: one WR pulse each. Group sum 361 -> 90.
    w0 = wr_falls;
    conv(8'h40, 40, 1'b1);
    conv(8'h41, 40, 1'b1);
    q_m.push_back(8'd90);
    conv(8'h43, 40, 1'b1);
    chk("busy_wr_pulses", wr_falls - w0, 3);

    // Timeout: INTR never comes; oError rises 100 cycles after WR_n rises.
    intr_en = 1'b0;
    pulse_ce();
    n = 0;
    while (wr_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!wr_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!err_m && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 100);
    chk("timeout_error_p", int'(err_p), 1);
    repeat (20) @(negedge clk);
    chk("timeout_idle_wr", int'(wr_m), 1);

    // Normal conversions after the timeout; the flag stays set.
    group4(8'd1, 8'd2, 8'd3, 8'd6, 8'd3, 30);
    chk("sticky_error_m", int'(err_m), 1);
    chk("sticky_error_p", int'(err_p), 1);

    // Reset during RD_LOW drops a partial group.
    conv(8'd7, 20, 1'b0);
    conv(8'd8, 20, 1'b0);
    adc_db     = 8'd9;
    intr_delay = 20;
    intr_en    = 1'b1;
    pulse_ce();
    n = 0;
    while (rd_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rd_reached", int'(rd_m), 0);
    repeat (3) @(negedge clk);
    cut   = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs", int'(cs_m), 1);
    chk("mid_rst_wr", int'(wr_m), 1);
    chk("mid_rst_rd", int'(rd_m), 1);
    chk("mid_rst_data", int'(dat_m), 0);
    chk("mid_rst_valid", int'(val_m), 0);
    chk("mid_rst_error", int'(err_m), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cut = 1'b0;
    repeat (5) @(negedge clk);

    // Fresh group after reset: 404 >> 2 = 101.
    group4(8'd100, 8'd100, 8'd100, 8'd104, 8'd101, 50);
    chk("final_error", int'(err_m), 0);

    repeat (20) @(negedge clk);
    chk("queue_m_drained", q_m.size(), 0);
    chk("queue_p_drained", q_p.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
